gamepad_emulator: RTL and testbench
===================================

# gamepad_emulator

Controller-side counterpart of the NES/SNES gamepad host interface. It presents a local button set as a virtual NES (8-bit) or SNES (16-bit) pad. It responds to host-driven `controller_latch`/`controller_clk` and drives the serial `data` line, behaving like the 4021 shift-register chain in a real pad. It is used for loopback verification of the host receiver and for board-to-board link play.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchronizer depth on `controller_latch`/`controller_clk`. Minimum 2.

Ports:
- `clk_50` in 1: 50 MHz system clock.
- `reset` in 1: synchronous, active-high.
- `controller_latch` in 1: host latch, asynchronous.
- `controller_clk` in 1: host shift clock, asynchronous, idles high.
- `is_snes` in 1: 1 = 16-bit SNES frame, 0 = 8-bit NES frame. Sampled on latch fall.
- `btn_a`, `btn_b`, `btn_select`, `btn_start`, `btn_up`, `btn_down`, `btn_left`, `btn_right` in 1 each: active-high, pressed.
- `btn_x`, `btn_y`, `btn_l`, `btn_r` in 1 each: active-high, pressed. SNES only.
- `data` out 1: serial button bit, active-low (0 = pressed).
- `frame_done` out 1: one-cycle pulse when the last frame bit has been shifted past.
- `poll_count` out 8: count of completed frames, wraps 255 -> 0.

## Operation
- Reset values: `data`=1, `frame_done`=0, `poll_count`=0, shift register all 1s, bit counter 0, state IDLE.
- Both host inputs pass through `SYNC_STAGES` flops. Edge detection compares the synchronized value with a one-cycle-delayed copy.
- Frame order, bit 0 first:
  - NES: A, B, Select, Start, Up, Down, Left, Right.
  - SNES: B, Y, Select, Start, Up, Down, Left, Right, A, X, L, R, then four 1s.
- Shift register, 16 bits. Loaded value is the inverted buttons in frame order. For NES, bits 8–15 are 1.
- `data` = shift register bit 0 in every state except DONE, where it is forced to 1.
- States:
  - IDLE: waits for synchronized latch high -> LOAD.
  - LOAD: reloads the shift register every cycle while latch is high, so the last button values before latch fall are captured. Clock edges are ignored. Latch fall -> SHIFT, with bit counter = 0 and frame length = 16 if `is_snes`, else 8.
  - SHIFT: on each rising `controller_clk` edge, shift right, fill with 1, increment the bit counter.
    - When the counter reaches the frame length: -> DONE, pulse `frame_done`, increment `poll_count`.
    - Falling clock edges do nothing.
  - DONE: `data`=1. Clock edges are ignored. Latch high -> LOAD.
- A latch rise in any state forces LOAD. This aborts a partial frame: no `frame_done`, no count.
- If a latch rise and a clock rise are detected in the same cycle, the latch wins and no shift occurs.
- Button inputs are used as-is. The caller guarantees they are synchronous to `clk_50`.

## Timing
- Pin edge to `data` change is exactly `SYNC_STAGES`+1 `clk_50` cycles (3 with the default). This is well inside the host's 150-cycle sample offset.
- Latch rise: the first bit is valid on `data` within 3 cycles and remains valid after latch fall until the first clock rise.
- `frame_done` asserts 3 cycles after the final clock rise, high for 1 cycle.
- `is_snes` changes take effect only at the next latch fall.

## Configuration
- `GAMEPAD_EMU_SNES_EN` defined: 16-bit SNES mode is available via `is_snes`.
- `GAMEPAD_EMU_SNES_EN` not defined:
  - `is_snes` is ignored and every frame is 8 bits (NES).
  - `btn_x`/`btn_y`/`btn_l`/`btn_r` are unused.
  - The shift register and counter shrink to 8 bits and 3 bits plus the done flag.

## Structure
- Package `gamepad_pkg`:
  - frame bit-index constants for NES and SNES order
  - frame lengths 8/16
  - state encoding IDLE/LOAD/SHIFT/DONE
- Sub-module `gamepad_sync`: parameterized N-flop synchronizer plus rising/falling edge detect, instantiated twice (latch, clk).

## Test plan
- Reset, then idle inputs -> `data`=1, `poll_count`=0, no `frame_done`.
- NES: press A and Start, latch 300 cycles, then 8 clocks (150 high / 150 low) -> host samples 0,1,1,0,1,1,1,1. `frame_done` pulses once, `poll_count`=1, then `data`=1.
- SNES: press B, X, R, latch, 16 clocks -> samples 0,1,1,1,1,1,1,1,1,0,1,0,1,1,1,1. Extra 6 clocks leave `data`=1, `poll_count` increments once.
- Abort: latch re-asserts after 3 clocks of an SNES frame -> no `frame_done`, reload, and the next full frame completes normally.
- Same-cycle latch rise and clock rise (NES host wrap) -> no shift, first bit correct.
- Without `GAMEPAD_EMU_SNES_EN`, `is_snes`=1 -> 8-bit frame, `frame_done` after the 8th clock. Separately, 256 full frames -> `poll_count` wraps to 0.

Source files
------------

// File: rtl/gamepad_pkg.sv
// Shared types and constants for the NES/SNES gamepad emulator: frame bit order,
// frame lengths, FSM state encoding and the frame image builder.
package gamepad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } state_t;

  localparam int NES_LEN  = 8;
  localparam int SNES_LEN = 16;

  localparam int NES_A      = 0;
  localparam int NES_B      = 1;
  localparam int NES_SELECT = 2;
  localparam int NES_START  = 3;
  localparam int NES_UP     = 4;
  localparam int NES_DOWN   = 5;
  localparam int NES_LEFT   = 6;
  localparam int NES_RIGHT  = 7;

  localparam int SNES_B      = 0;
  localparam int SNES_Y      = 1;
  localparam int SNES_SELECT = 2;
  localparam int SNES_START  = 3;
  localparam int SNES_UP     = 4;
  localparam int SNES_DOWN   = 5;
  localparam int SNES_LEFT   = 6;
  localparam int SNES_RIGHT  = 7;
  localparam int SNES_A      = 8;
  localparam int SNES_X      = 9;
  localparam int SNES_L      = 10;
  localparam int SNES_R      = 11;

  typedef struct packed {
    logic a, b, select, start, up, down, left, right, x, y, l, r;
  } buttons_t;

  // Active-low image in frame order; positions past the frame stay 1.
  function automatic logic [15:0] frame_image(input buttons_t btn, input logic snes);
    logic [15:0] img;
    img = '1;
    if (snes) begin
      img[SNES_B]      = ~btn.b;
      img[SNES_Y]      = ~btn.y;
      img[SNES_SELECT] = ~btn.select;
      img[SNES_START]  = ~btn.start;
      img[SNES_UP]     = ~btn.up;
      img[SNES_DOWN]   = ~btn.down;
      img[SNES_LEFT]   = ~btn.left;
      img[SNES_RIGHT]  = ~btn.right;
      img[SNES_A]      = ~btn.a;
      img[SNES_X]      = ~btn.x;
      img[SNES_L]      = ~btn.l;
      img[SNES_R]      = ~btn.r;
    end else begin
      img[NES_A]      = ~btn.a;
      img[NES_B]      = ~btn.b;
      img[NES_SELECT] = ~btn.select;
      img[NES_START]  = ~btn.start;
      img[NES_UP]     = ~btn.up;
      img[NES_DOWN]   = ~btn.down;
      img[NES_LEFT]   = ~btn.left;
      img[NES_RIGHT]  = ~btn.right;
    end
    return img;
  endfunction

endpackage

// File: rtl/gamepad_if.sv
// Host <-> pad serial link: the host drives latch and shift clock, the pad drives data.
interface gamepad_if;
  logic controller_latch;
  logic controller_clk;
  logic data;

  modport master (output controller_latch, output controller_clk, input data);
  modport slave  (input controller_latch, input controller_clk, output data);
endinterface

// File: rtl/gamepad_sync.sv
// N-flop synchronizer for an asynchronous host pin with rising/falling edge detect
// against a one-cycle-delayed copy of the synchronized level.
module gamepad_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_50,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Reset to the pin's idle level so no phantom edge appears after reset.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], pin};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/gamepad_emulator.sv
// Virtual NES/SNES pad emulating the 4021 shift chain on host latch/clock.
// Define GAMEPAD_EMU_SNES_EN to enable 16-bit SNES frames via is_snes.
module gamepad_emulator
  import gamepad_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_50,
  input  logic       reset,
  gamepad_if.slave   pad,
  input  logic       is_snes,
  input  logic       btn_a,
  input  logic       btn_b,
  input  logic       btn_select,
  input  logic       btn_start,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_x,
  input  logic       btn_y,
  input  logic       btn_l,
  input  logic       btn_r,
  output logic       frame_done,
  output logic [7:0] poll_count
);

`ifdef GAMEPAD_EMU_SNES_EN
  localparam int SR_W = SNES_LEN;
  logic snes_mode;
  assign snes_mode = is_snes;
`else
  localparam int SR_W = NES_LEN;
  logic snes_mode;
  logic unused_is_snes;
  assign snes_mode      = 1'b0;
  assign unused_is_snes = is_snes;
`endif

  localparam int                 CNT_W     = $clog2(SR_W);
  localparam logic [CNT_W-1:0]   LAST_LONG = CNT_W'(SR_W - 1);
  localparam logic [CNT_W-1:0]   LAST_NES  = CNT_W'(NES_LEN - 1);

  logic latch_lvl, latch_rise, latch_fall;
  logic clk_rise, unused_clk_lvl, unused_clk_fall;

  gamepad_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_latch_sync (
    .clk_50 (clk_50),
    .reset  (reset),
    .pin    (pad.controller_latch),
    .level  (latch_lvl),
    .rise   (latch_rise),
    .fall   (latch_fall)
  );

  gamepad_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_clk_sync (
    .clk_50 (clk_50),
    .reset  (reset),
    .pin    (pad.controller_clk),
    .level  (unused_clk_lvl),
    .rise   (clk_rise),
    .fall   (unused_clk_fall)
  );

  buttons_t    btns;
  logic [15:0] frame_img;
  logic [SR_W-1:0] load_val;

  assign btns = '{a: btn_a, b: btn_b, select: btn_select, start: btn_start,
                  up: btn_up, down: btn_down, left: btn_left, right: btn_right,
                  x: btn_x, y: btn_y, l: btn_l, r: btn_r};
  assign frame_img = frame_image(btns, snes_mode);
  assign load_val  = frame_img[SR_W-1:0];

`ifndef GAMEPAD_EMU_SNES_EN
  logic [7:0] unused_img_hi;
  assign unused_img_hi = frame_img[15:8];
`endif

  state_t            state;
  logic [SR_W-1:0]   sr;
  logic [CNT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  last_idx;

  always_ff @(posedge clk_50) begin
    if (reset) begin
      state      <= ST_IDLE;
      sr         <= '1;
      bit_cnt    <= '0;
      last_idx   <= LAST_NES;
      frame_done <= 1'b0;
      poll_count <= '0;
    end else begin
      frame_done <= 1'b0;
      if (latch_rise) begin
        state <= ST_LOAD;
        sr    <= load_val;
      end else begin
        case (state)
          ST_IDLE, ST_DONE: begin
            if (latch_lvl) begin
              state <= ST_LOAD;
              sr    <= load_val;
            end
          end
          // Reload on the fall cycle too so image order and frame length
          // always come from the same is_snes sample.
          ST_LOAD: begin
            sr <= load_val;
            if (latch_fall) begin
              state    <= ST_SHIFT;
              bit_cnt  <= '0;
              last_idx <= snes_mode ? LAST_LONG : LAST_NES;
            end
          end
          ST_SHIFT: begin
            if (clk_rise) begin
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == last_idx) begin
                state      <= ST_DONE;
                sr         <= '1;
                frame_done <= 1'b1;
                poll_count <= poll_count + 1'b1;
              end else begin
                sr <= {1'b1, sr[SR_W-1:1]};
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // sr is all ones throughout DONE, so data idles high there.
  assign pad.data = sr[0];

endmodule

// File: tb/tb_gamepad_emulator.sv
// Self-checking bench for gamepad_emulator: host-level frame model with a
// pin-to-output latency pipeline, plus literal host-sample expectations.
module tb_gamepad_emulator;

`ifdef GAMEPAD_EMU_SNES_EN
  localparam bit SNES_EN = 1'b1;
`else
  localparam bit SNES_EN = 1'b0;
`endif

  logic clk_50 = 1'b0;
  always #10 clk_50 = ~clk_50;

  logic reset = 1'b1;
  logic is_snes = 1'b0;
  logic b_a = 0, b_b = 0, b_sel = 0, b_start = 0, b_up = 0, b_down = 0;
  logic b_left = 0, b_right = 0, b_x = 0, b_y = 0, b_l = 0, b_r = 0;
  logic       frame_done;
  logic [7:0] poll_count;

  gamepad_if bus();

  gamepad_emulator #(.SYNC_STAGES(2)) dut (
    .clk_50     (clk_50),
    .reset      (reset),
    .pad        (bus),
    .is_snes    (is_snes),
    .btn_a      (b_a),
    .btn_b      (b_b),
    .btn_select (b_sel),
    .btn_start  (b_start),
    .btn_up     (b_up),
    .btn_down   (b_down),
    .btn_left   (b_left),
    .btn_right  (b_right),
    .btn_x      (b_x),
    .btn_y      (b_y),
    .btn_l      (b_l),
    .btn_r      (b_r),
    .frame_done (frame_done),
    .poll_count (poll_count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Host-level model: what the pad presents given the pin history.
  logic        m_latched = 0, m_in_frame = 0, m_done = 0, m_fd_evt = 0;
  int          m_pos = 0, m_len = 8;
  logic [15:0] m_img = '1;
  logic [7:0]  m_count = 0;
  logic        chk_en = 0;
  int          fd_seen = 0;

  function automatic logic [15:0] model_image(input logic snes);
    logic [15:0] img;
    img = '1;
    if (snes) begin
      img[0] = ~b_b;    img[1] = ~b_y;     img[2]  = ~b_sel;  img[3]  = ~b_start;
      img[4] = ~b_up;   img[5] = ~b_down;  img[6]  = ~b_left; img[7]  = ~b_right;
      img[8] = ~b_a;    img[9] = ~b_x;     img[10] = ~b_l;    img[11] = ~b_r;
    end else begin
      img[0] = ~b_a;    img[1] = ~b_b;     img[2]  = ~b_sel;  img[3]  = ~b_start;
      img[4] = ~b_up;   img[5] = ~b_down;  img[6]  = ~b_left; img[7]  = ~b_right;
    end
    return img;
  endfunction

  function automatic logic ideal_data();
    if (m_latched) return m_img[0];
    if (m_in_frame && !m_done) return m_img[m_pos];
    return 1'b1;
  endfunction

  // Effect of a pin edge is visible exactly three clk_50 edges later.
  logic       h_data [3];
  logic       h_fd   [3];
  logic [7:0] h_cnt  [3];

  always @(posedge clk_50) begin
    #5;
    for (int i = 2; i > 0; i--) begin
      h_data[i] = h_data[i-1];
      h_fd[i]   = h_fd[i-1];
      h_cnt[i]  = h_cnt[i-1];
    end
    h_data[0] = ideal_data();
    h_fd[0]   = m_fd_evt;
    m_fd_evt  = 1'b0;
    h_cnt[0]  = m_count;
    if (frame_done === 1'b1) fd_seen++;
    if (chk_en) begin
      check("data", int'(bus.data), int'(h_data[2]));
      check("frame_done", int'(frame_done), int'(h_fd[2]));
      check("poll_count", int'(poll_count), int'(h_cnt[2]));
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_50);
  endtask

  task automatic model_latch(input logic v);
    if (v && !bus.controller_latch) begin
      m_latched = 1; m_in_frame = 0; m_done = 0;
      m_img = model_image(SNES_EN && is_snes);
    end else if (!v && bus.controller_latch) begin
      m_latched = 0; m_in_frame = 1; m_pos = 0;
      m_len = (SNES_EN && is_snes) ? 16 : 8;
    end
  endtask

  task automatic model_clk(input logic v);
    if (v && !bus.controller_clk && m_in_frame && !m_done && !m_latched) begin
      m_pos++;
      if (m_pos == m_len) begin
        m_done = 1; m_fd_evt = 1; m_count++;
      end
    end
  endtask

  task automatic set_latch(input logic v);
    @(negedge clk_50);
    model_latch(v);
    bus.controller_latch = v;
  endtask

  task automatic set_clk(input logic v);
    @(negedge clk_50);
    model_clk(v);
    bus.controller_clk = v;
  endtask

  task automatic set_both_high();
    @(negedge clk_50);
    model_latch(1'b1);
    model_clk(1'b1);
    bus.controller_latch = 1'b1;
    bus.controller_clk   = 1'b1;
  endtask

  task automatic shift_bits(input int phase, input int nbits, output logic [15:0] samples);
    samples = '1;
    for (int i = 0; i < nbits; i++) begin
      wait_cyc(phase);
      samples[i] = bus.data;
      set_clk(1'b0);
      wait_cyc(phase);
      set_clk(1'b1);
    end
    wait_cyc(phase);
  endtask

  task automatic host_frame(input int latch_cyc, input int phase, input int nbits,
                            output logic [15:0] samples);
    set_latch(1'b1);
    wait_cyc(latch_cyc);
    set_latch(1'b0);
    shift_bits(phase, nbits, samples);
  endtask

  task automatic set_buttons(input logic [11:0] v);
    {b_a, b_b, b_sel, b_start, b_up, b_down, b_left, b_right, b_x, b_y, b_l, b_r} = v;
  endtask

  task automatic do_reset();
    chk_en = 0;
    @(negedge clk_50);
    reset = 1;
    bus.controller_latch = 1'b0;
    bus.controller_clk   = 1'b1;
    m_latched = 0; m_in_frame = 0; m_done = 0; m_fd_evt = 0;
    m_pos = 0; m_len = 8; m_count = 0;
    wait_cyc(3);
    reset = 0;
    wait_cyc(4);
    chk_en = 1;
  endtask

  logic [15:0] smp;

  initial begin
    bus.controller_latch = 1'b0;
    bus.controller_clk   = 1'b1;
    do_reset();

    // Idle after reset
    fd_seen = 0;
    check("reset_data", int'(bus.data), 1);
    check("reset_poll_count", int'(poll_count), 0);
    check("reset_frame_done", int'(frame_done), 0);
    wait_cyc(20);
    check("idle_no_frame_done", fd_seen, 0);

    // NES: A + Start
    is_snes = 1'b0;
    set_buttons(12'b1001_0000_0000);
    fd_seen = 0;
    host_frame(300, 150, 8, smp);
    check("nes_samples", int'(smp[7:0]), 8'hF6);
    check("nes_fd_pulses", fd_seen, 1);
    check("nes_poll_count", int'(poll_count), 1);
    check("nes_data_after", int'(bus.data), 1);

    // SNES: B + X + R, then six extra clocks
    wait_cyc(10);
    is_snes = 1'b1;
    set_buttons(12'b0100_0000_1001);
    fd_seen = 0;
    host_frame(300, 150, SNES_EN ? 16 : 8, smp);
    if (SNES_EN) check("snes_samples", int'(smp), 16'hF5FE);
    else         check("nes_only_samples", int'(smp[7:0]), 8'hFD);
    shift_bits(150, 6, smp);
    check("snes_extra_data", int'(smp[5:0]), 6'h3F);
    check("snes_fd_pulses", fd_seen, 1);
    check("snes_poll_count", int'(poll_count), 2);

    // Abort after three clocks, then a full frame
    wait_cyc(10);
    fd_seen = 0;
    set_latch(1'b1);
    wait_cyc(20);
    set_latch(1'b0);
    shift_bits(20, 3, smp);
    host_frame(40, 20, SNES_EN ? 16 : 8, smp);
    if (SNES_EN) check("abort_next_samples", int'(smp), 16'hF5FE);
    else         check("abort_next_samples", int'(smp[7:0]), 8'hFD);
    check("abort_fd_pulses", fd_seen, 1);
    check("abort_poll_count", int'(poll_count), 3);

    // Latch rise and clock rise on the same cycle mid-frame
    wait_cyc(10);
    is_snes = 1'b0;
    set_buttons(12'b1001_0000_0000);
    fd_seen = 0;
    set_latch(1'b1);
    wait_cyc(20);
    set_latch(1'b0);
    shift_bits(20, 3, smp);
    set_clk(1'b0);
    wait_cyc(20);
    set_both_high();
    wait_cyc(30);
    check("wrap_first_bit", int'(bus.data), 0);
    set_latch(1'b0);
    shift_bits(20, 8, smp);
    check("wrap_samples", int'(smp[7:0]), 8'hF6);
    check("wrap_fd_pulses", fd_seen, 1);
    check("wrap_poll_count", int'(poll_count), 4);

    // 256 short frames wrap poll_count
    do_reset();
    for (int f = 0; f < 256; f++) begin
      @(negedge clk_50);
      set_buttons(12'(f * 37));
      host_frame(4, 5, 8, smp);
      if (f == 254) check("poll_count_255", int'(poll_count), 255);
    end
    check("poll_count_wrap", int'(poll_count), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
